immediate_generator_pfx: RTL and testbench

Parametrised, registered immediate generator for the register-stack CPU decode stage. It extracts the immediate field from each accepted instruction and extends it to the datapath width: zero-extended for data opcodes, sign-extended for branch offsets. A PREFIX instruction supplies upper immediate bits, which the next immediate-consuming instruction concatenates to build a full-width constant. Output is registered, one cycle after acceptance, and feeds the stack/ALU operand mux and the branch adder.

---
 rtl/immediate_generator_pkg.sv | 39 +++
 rtl/immediate_generator_pfx_imm_extend.sv | 38 +++
 rtl/immediate_generator_pfx.sv | 103 ++++++++++
 tb/tb_immediate_generator_pfx.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/immediate_generator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : immediate_generator_pkg
//  Brief    : Opcode constants, immediate class enum and opcode classifier
//             shared by the immediate generator and its extender.
//  Revision : 1.0
// ============================================================================
package immediate_generator_pkg;

    // Opcodes are compared at this width so OPC_W may vary up to it.
    localparam int OPC_CMP_W = 8;

    localparam logic [OPC_CMP_W-1:0] OPC_PUSH = 8'h02;
    localparam logic [OPC_CMP_W-1:0] OPC_JNZ  = 8'h03;
    localparam logic [OPC_CMP_W-1:0] OPC_POP  = 8'h04;
    localparam logic [OPC_CMP_W-1:0] OPC_LI   = 8'h05;
    localparam logic [OPC_CMP_W-1:0] OPC_JMP  = 8'h0E;
    localparam logic [OPC_CMP_W-1:0] OPC_PFX  = 8'h0F;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_UNS  = 2'd1,
        CLS_SGN  = 2'd2,
        CLS_PFX  = 2'd3
    } imm_cls_e;

    function automatic imm_cls_e classify(input logic [OPC_CMP_W-1:0] opc);
        imm_cls_e cls;
        case (opc)
            OPC_PFX:                   cls = CLS_PFX;
            OPC_JNZ, OPC_JMP:          cls = CLS_SGN;
            OPC_PUSH, OPC_POP, OPC_LI: cls = CLS_UNS;
            default:                   cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/immediate_generator_pfx_imm_extend.sv
`default_nettype none
// ============================================================================
//  Module   : imm_extend
//  Brief    : Combinational zero/sign extender with optional prefix concat.
//  Revision : 1.0
// ============================================================================
module imm_extend
    import immediate_generator_pkg::*;
#(
    parameter int IMM_W  = 12,
    parameter int PFX_W  = 4,
    parameter int DATA_W = 16
) (
    input  logic [IMM_W-1:0]  i_field,
    input  logic [PFX_W-1:0]  i_prefix,
    input  imm_cls_e          i_cls,
    input  logic              i_use_prefix,
    output logic [DATA_W-1:0] o_value
);

    always_comb begin
        o_value = '0;
        case (i_cls)
            CLS_UNS, CLS_SGN: begin
                // A prefix supplies the upper bits verbatim, so no sign fill.
                if (i_use_prefix)
                    o_value = {i_prefix, i_field};
                else if (i_cls == CLS_SGN)
                    o_value = {{PFX_W{i_field[IMM_W-1]}}, i_field};
                else
                    o_value = {{PFX_W{1'b0}}, i_field};
            end
            default: o_value = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/immediate_generator_pfx.sv
`default_nettype none
// ============================================================================
//  Module   : immediate_generator_pfx
//  Brief    : Registered immediate generator with PREFIX upper-bit support.
//  Revision : 1.0
// ============================================================================
module immediate_generator_pfx
    import immediate_generator_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 4,
    parameter int DATA_W  = 16
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic [INSTR_W-1:0] in_instruction,
    input  logic               in_valid,
    input  logic               in_stall,
    output logic [DATA_W-1:0]  ot_immediate_output,
    output logic               ot_valid,
    output logic               ot_has_imm,
    output logic               ot_prefix_pending,
    output logic               ot_prefix_err
);

    localparam int IMM_W = INSTR_W - OPC_W;
    localparam int PFX_W = DATA_W - IMM_W;

    if ((DATA_W < INSTR_W) || (DATA_W > 2 * IMM_W)) begin : g_bad_data_w
        $error("immediate_generator_pfx: DATA_W outside INSTR_W..2*(INSTR_W-OPC_W)");
    end
    if (OPC_W > OPC_CMP_W) begin : g_bad_opc_w
        $error("immediate_generator_pfx: OPC_W wider than package opcode width");
    end

    logic [OPC_W-1:0]  w_opcode;
    logic [IMM_W-1:0]  w_field;
    imm_cls_e          w_cls;
    logic [DATA_W-1:0] w_ext_value;
    logic              w_accept;

    logic [PFX_W-1:0]  r_prefix;
    logic              r_pending;
    logic [DATA_W-1:0] r_value;
    logic              r_valid;
    logic              r_has_imm;
    logic              r_prefix_err;

    assign w_opcode = in_instruction[OPC_W-1:0];
    assign w_field  = in_instruction[INSTR_W-1:OPC_W];
    assign w_cls    = classify(OPC_CMP_W'(w_opcode));
    assign w_accept = in_valid & ~in_stall;

    imm_extend #(
        .IMM_W  (IMM_W),
        .PFX_W  (PFX_W),
        .DATA_W (DATA_W)
    ) u_imm_extend (
        .i_field      (w_field),
        .i_prefix     (r_prefix),
        .i_cls        (w_cls),
        .i_use_prefix (r_pending),
        .o_value      (w_ext_value)
    );

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_prefix     <= '0;
            r_pending    <= 1'b0;
            r_value      <= '0;
            r_valid      <= 1'b0;
            r_has_imm    <= 1'b0;
            r_prefix_err <= 1'b0;
        end else if (in_stall) begin
            r_prefix_err <= 1'b0;
        end else if (w_accept) begin
            if (w_cls == CLS_PFX) begin
                // Value and has_imm keep describing the last real result.
                r_prefix     <= w_field[PFX_W-1:0];
                r_pending    <= 1'b1;
                r_valid      <= 1'b0;
                r_prefix_err <= r_pending;
            end else begin
                r_value      <= w_ext_value;
                r_valid      <= 1'b1;
                r_has_imm    <= (w_cls != CLS_NONE);
                r_pending    <= 1'b0;
                r_prefix_err <= r_pending & (w_cls == CLS_NONE);
            end
        end else begin
            r_valid      <= 1'b0;
            r_prefix_err <= 1'b0;
        end
    end

    assign ot_immediate_output = r_value;
    assign ot_valid            = r_valid;
    assign ot_has_imm          = r_has_imm;
    assign ot_prefix_pending   = r_pending;
    assign ot_prefix_err       = r_prefix_err;

endmodule
`default_nettype wire

// File: tb/tb_immediate_generator_pfx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_immediate_generator_pfx
//  Brief    : Table-driven scoreboard bench for immediate_generator_pfx.
//  Revision : 1.0
// ============================================================================
module tb_immediate_generator_pfx;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic        valid;
    logic        stall;
    logic [15:0] imm_out;
    logic        o_valid;
    logic        o_has_imm;
    logic        o_pending;
    logic        o_err;

    immediate_generator_pfx #(
        .INSTR_W (16),
        .OPC_W   (4),
        .DATA_W  (16)
    ) dut (
        .in_clk              (clk),
        .in_rst              (rst),
        .in_instruction      (instr),
        .in_valid            (valid),
        .in_stall            (stall),
        .ot_immediate_output (imm_out),
        .ot_valid            (o_valid),
        .ot_has_imm          (o_has_imm),
        .ot_prefix_pending   (o_pending),
        .ot_prefix_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] instr;
        logic        valid;
        logic        stall;
        logic [15:0] imm;
        logic        ovalid;
        logic        has;
        logic        pend;
        logic        err;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void add(input logic r, input logic [15:0] in, input logic v,
                                input logic s, input logic [15:0] im, input logic ov,
                                input logic h, input logic p, input logic e);
        vec_t t;
        t.rst = r; t.instr = in; t.valid = v; t.stall = s;
        t.imm = im; t.ovalid = ov; t.has = h; t.pend = p; t.err = e;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] got,
                       input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step%0d %s: got %h want %h", idx, name, got, want);
        end
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge.
    task automatic step(input vec_t t, input int idx);
        vec_t e;
        @(negedge clk);
        rst = t.rst; instr = t.instr; valid = t.valid; stall = t.stall;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("imm",     idx, imm_out,          e.imm);
        chk("valid",   idx, 16'(o_valid),     16'(e.ovalid));
        chk("has_imm", idx, 16'(o_has_imm),   16'(e.has));
        chk("pending", idx, 16'(o_pending),   16'(e.pend));
        chk("err",     idx, 16'(o_err),       16'(e.err));
    endtask

    initial begin
        vec_t t;
        rst = 1'b1; instr = '0; valid = 1'b0; stall = 1'b0;

        //  rst  instr    v  s  imm      ov h  p  e
        add(1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0);  // reset cycle 1
        add(1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0);  // reset cycle 2
        add(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0);  // released, idle
        add(0, 16'h0082, 1, 0, 16'h0008, 1, 1, 0, 0);  // push
        add(0, 16'h0213, 1, 0, 16'h0021, 1, 1, 0, 0);  // jnz
        add(0, 16'hFD0E, 1, 0, 16'hFFD0, 1, 1, 0, 0);  // jmp negative
        add(0, 16'h0007, 1, 0, 16'h0000, 1, 0, 0, 0);  // add, no imm
        add(0, 16'h00AF, 1, 0, 16'h0000, 0, 0, 1, 0);  // PFX A
        add(0, 16'h1232, 1, 0, 16'hA123, 1, 1, 0, 0);  // push prefixed
        add(0, 16'h00AF, 1, 0, 16'hA123, 0, 1, 1, 0);  // PFX A
        add(0, 16'h0007, 1, 0, 16'h0000, 1, 0, 0, 1);  // add discards prefix
        add(0, 16'h0052, 1, 0, 16'h0005, 1, 1, 0, 0);  // push unprefixed
        add(0, 16'h0000, 0, 0, 16'h0005, 0, 1, 0, 0);  // idle bubble
        add(0, 16'h0082, 1, 0, 16'h0008, 1, 1, 0, 0);  // push
        add(0, 16'h1235, 1, 1, 16'h0008, 1, 1, 0, 0);  // stall x3
        add(0, 16'h00AF, 1, 1, 16'h0008, 1, 1, 0, 0);
        add(0, 16'h0007, 0, 1, 16'h0008, 1, 1, 0, 0);
        add(0, 16'h003F, 1, 0, 16'h0008, 0, 1, 1, 0);  // PFX 3
        add(0, 16'h007F, 1, 0, 16'h0008, 0, 1, 1, 1);  // PFX 7 replaces
        add(0, 16'h0015, 1, 1, 16'h0008, 0, 1, 1, 0);  // stall forces err low
        add(0, 16'h0015, 1, 0, 16'h7001, 1, 1, 0, 0);  // li prefixed
        add(0, 16'h7FFE, 1, 0, 16'h07FF, 1, 1, 0, 0);  // jmp max positive
        add(0, 16'h00CF, 1, 0, 16'h07FF, 0, 1, 1, 0);  // PFX C
        add(0, 16'h800E, 1, 0, 16'hC800, 1, 1, 0, 0);  // jmp prefixed, no sign fill
        add(0, 16'hFFF4, 1, 0, 16'h0FFF, 1, 1, 0, 0);  // pop all-ones field

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // Reset while a prefix is pending drops it without an error pulse.
        t = '{rst:0, instr:16'h005F, valid:1, stall:0, imm:16'h0FFF, ovalid:0, has:1, pend:1, err:0};
        step(t, 100);
        t = '{rst:1, instr:16'h0007, valid:1, stall:0, imm:16'h0000, ovalid:0, has:0, pend:0, err:0};
        step(t, 101);
        t = '{rst:0, instr:16'h0007, valid:1, stall:0, imm:16'h0000, ovalid:1, has:0, pend:0, err:0};
        step(t, 102);
        t = '{rst:0, instr:16'h0012, valid:1, stall:0, imm:16'h0001, ovalid:1, has:1, pend:0, err:0};
        step(t, 103);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
        end
        checks++;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
